// File: rtl/axi_stream_dw_downsizer.sv
// axi_stream_dw_downsizer: serialises each wide AXI-Stream beat into Ratio narrow subbeats, MS subword first.
// Define AXI_STREAM_DW_DOWNSIZER_KEEP_TRIM_EN to drop trailing all-zero-keep subwords on last beats.
module axi_stream_dw_downsizer #(
    parameter int DataWidthIn  = 32,
    parameter int DataWidthOut = 8,
    parameter int IdWidth      = 0,
    parameter int DestWidth    = 0,
    parameter int UserWidth    = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  in_tvalid_i,
    output logic                                  in_tready_o,
    input  logic [DataWidthIn-1:0]                in_tdata_i,
    input  logic [DataWidthIn/8-1:0]              in_tstrb_i,
    input  logic [DataWidthIn/8-1:0]              in_tkeep_i,
    input  logic                                  in_tlast_i,
    input  logic [(IdWidth > 0 ? IdWidth : 1)-1:0]     in_tid_i,
    input  logic [(DestWidth > 0 ? DestWidth : 1)-1:0] in_tdest_i,
    input  logic [(UserWidth > 0 ? UserWidth : 1)-1:0] in_tuser_i,
    output logic                                  out_tvalid_o,
    input  logic                                  out_tready_i,
    output logic [DataWidthOut-1:0]               out_tdata_o,
    output logic [DataWidthOut/8-1:0]             out_tstrb_o,
    output logic [DataWidthOut/8-1:0]             out_tkeep_o,
    output logic                                  out_tlast_o,
    output logic [(IdWidth > 0 ? IdWidth : 1)-1:0]     out_tid_o,
    output logic [(DestWidth > 0 ? DestWidth : 1)-1:0] out_tdest_o,
    output logic [(UserWidth > 0 ? UserWidth : 1)-1:0] out_tuser_o
);
    localparam int Ratio = DataWidthIn / DataWidthOut;
    localparam int BI    = DataWidthIn / 8;
    localparam int SW    = DataWidthOut / 8;
    localparam int CW    = $clog2(Ratio);
    localparam int IW    = IdWidth > 0 ? IdWidth : 1;
    localparam int DW    = DestWidth > 0 ? DestWidth : 1;
    localparam int UW    = UserWidth > 0 ? UserWidth : 1;

    typedef enum logic {EMPTY, SEND} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic [DataWidthIn-1:0] data_q, data_d;
    logic [BI-1:0]          strb_q, strb_d, keep_q, keep_d;
    logic                   last_q, last_d;
    logic [IW-1:0]          id_q, id_d;
    logic [DW-1:0]          dest_q, dest_d;
    logic [UW-1:0]          user_q, user_d;
    logic [CW-1:0]          last_idx;
    logic                   full_q, vld, fin, acc;
    logic [DataWidthOut-1:0] sub_data;
    logic [SW-1:0]          sub_strb, sub_keep;

    assign full_q = state_q == SEND;
    assign vld    = full_q && !rst_i;

    always_comb begin
        last_idx = CW'(Ratio - 1);
`ifdef AXI_STREAM_DW_DOWNSIZER_KEEP_TRIM_EN
        // lowest-order subword with any keep bit; subword 0 is always sent
        if (last_q) begin
            last_idx = '0;
            for (int i = 1; i < Ratio; i++)
                if (|keep_q[BI-1-i*SW -: SW]) last_idx = CW'(i);
        end
`endif
    end

    always_comb begin
        sub_data = '0;
        sub_strb = '0;
        sub_keep = '0;
        for (int i = 0; i < Ratio; i++) begin
            if (idx_q == CW'(i)) begin
                sub_data = data_q[DataWidthIn-1-i*DataWidthOut -: DataWidthOut];
                sub_strb = strb_q[BI-1-i*SW -: SW];
                sub_keep = keep_q[BI-1-i*SW -: SW];
            end
        end
    end

    assign fin         = idx_q == last_idx;
    assign in_tready_o = !rst_i && (!full_q || (out_tready_i && fin));
    assign acc         = in_tvalid_i && in_tready_o;

    always_comb begin
        out_tvalid_o = vld;
        out_tdata_o  = vld ? sub_data : '0;
        out_tstrb_o  = vld ? sub_strb : '0;
        out_tkeep_o  = vld ? sub_keep : '0;
        out_tlast_o  = vld && last_q && fin;
        out_tid_o    = vld ? id_q : '0;
        out_tdest_o  = vld ? dest_q : '0;
        out_tuser_o  = vld ? user_q : '0;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        keep_d  = keep_q;
        last_d  = last_q;
        id_d    = id_q;
        dest_d  = dest_q;
        user_d  = user_q;
        if (full_q && out_tready_i) begin
            idx_d   = fin ? '0 : idx_q + 1'b1;
            state_d = fin ? EMPTY : SEND;
        end
        if (acc) begin
            state_d = SEND;
            idx_d   = '0;
            data_d  = in_tdata_i;
            strb_d  = in_tstrb_i;
            keep_d  = in_tkeep_i;
            last_d  = in_tlast_i;
            id_d    = IdWidth > 0 ? in_tid_i : '0;
            dest_d  = DestWidth > 0 ? in_tdest_i : '0;
            user_d  = UserWidth > 0 ? in_tuser_i : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= '0;
            dest_q  <= '0;
            user_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            id_q    <= id_d;
            dest_q  <= dest_d;
            user_q  <= user_d;
        end
    end
endmodule

// File: doc/axi_stream_dw_downsizer.md
Name: axi_stream_dw_downsizer

Overview:
- Converts a wide AXI-Stream (DataWidthIn) into a narrow AXI-Stream (DataWidthOut) by serialising each input beat into Ratio = DataWidthIn/DataWidthOut output subbeats, most-significant subword first.
- It is the inverse of the team's dw upsizer. Upsizer packs 8'h12,34,56,ef into 32'h12_34_56_ef; this block unpacks 32'h12_34_56_ef into 8'h12,34,56,ef.
- Sits between a wide internal datapath and a narrow stream sink.

Parameters:
- DataWidthIn, 32, input tdata width in bits. Must be an integer multiple of DataWidthOut, with Ratio >= 2.
- DataWidthOut, 8, output tdata width in bits. Must be a multiple of 8.
- IdWidth, 0, tid width. 0 means the field is absent (tied to 1 bit internally and ignored).
- DestWidth, 0, tdest width. 0 means absent.
- UserWidth, 0, tuser width. 0 means absent.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- in_tvalid_i  in  1  input beat valid.
- in_tready_o  out  1  input beat accepted.
- in_tdata_i  in  DataWidthIn  wide data.
- in_tstrb_i  in  DataWidthIn/8  byte strobes.
- in_tkeep_i  in  DataWidthIn/8  byte keeps.
- in_tlast_i  in  1  packet end.
- in_tid_i / in_tdest_i / in_tuser_i  in  IdWidth/DestWidth/UserWidth  sideband.
- out_tvalid_o  out  1  subbeat valid.
- out_tready_i  in  1  subbeat accepted.
- out_tdata_o  out  DataWidthOut  narrow data.
- out_tstrb_o / out_tkeep_o  out  DataWidthOut/8  sliced strobes/keeps.
- out_tlast_o  out  1  packet end.
- out_tid_o / out_tdest_o / out_tuser_o  out  same widths as inputs  sideband.

Behaviour:
- Storage: one holding register for the wide beat (data, strb, keep, last, id, dest, user), a valid flag full_q, and a subword counter idx_q in 0..Ratio-1.
- FSM states:
  - EMPTY (full_q=0).
  - SEND (full_q=1).
- Reset (rst_i=1 at a clock edge): state goes to EMPTY, idx_q=0, holding register cleared to 0.
  - All outputs read 0 during and after reset: out_tvalid_o=0, out_tdata_o=0, out_tlast_o=0, strb/keep/sideband outputs=0.
  - in_tready_o is 0 while rst_i=1.
  - Reset mid-packet discards the held beat with no further output.
- Input handshake: in_tready_o = !rst_i && (EMPTY || (SEND && out_tready_i && final subbeat)).
  - in_tready_o is combinational on out_tready_i; there is no path from in_tvalid_i to in_tready_o.
  - When in_tvalid_i && in_tready_o: capture the beat, set idx_q=0, go to or stay in SEND.
- Latency: the first subbeat appears on the cycle after input acceptance (1-cycle registered latency).
- Full throughput: Ratio output cycles per input beat, with no bubble between consecutive input beats while out_tready_i=1.
- Output in SEND:
  - out_tvalid_o=1.
  - out_tdata_o = held_data[DataWidthIn-1-idx_q*DataWidthOut -: DataWidthOut].
  - strb/keep are sliced identically.
  - tid/tdest/tuser are replicated on every subbeat.
- On out_tvalid_o && out_tready_i:
  - If not the final subbeat: idx_q+1.
  - Else: idx_q=0, and the next state is SEND if a new beat is accepted in the same cycle, otherwise EMPTY.
- Final subbeat is idx_q==Ratio-1. The optional feature below changes this.
- out_tlast_o = held_last && final subbeat. It is never asserted on earlier subbeats.
- Output stability: once out_tvalid_o=1, all out_* signals stay constant until out_tready_i=1 (AXI-Stream rule).
- Backpressure: out_tready_i=0 holds idx_q and the data indefinitely. in_tready_o stays 0 meanwhile.

Optional Feature:
- Macro: AXI_STREAM_DW_DOWNSIZER_KEEP_TRIM_EN.
- Defined:
  - On a beat with held_last=1, the final subbeat is the lowest-order subword that has any tkeep bit set.
  - Trailing subwords whose tkeep slice is all zero are not emitted, and tlast moves to the last emitted subbeat.
  - Subbeat 0 is always emitted, even when the whole tkeep is 0.
  - Beats with last=0 are never trimmed.
- Not defined: all Ratio subbeats are always emitted, regardless of tkeep.

Test Plan:
- Single beat: 32'h12_34_56_ef, last=0, keep=4'hF, out_tready_i=1 -> outputs 8'h12,34,56,ef on four consecutive cycles starting 1 cycle after acceptance; tlast=0 on all four.
- Same beat with last=1 -> tlast=1 only on the 8'hef subbeat; in_tready_o=1 in that same cycle.
- Two back-to-back beats 32'h12_34_56_ef then 32'hAA_BB_CC_DD, last=1 on the second -> eight contiguous subbeats with no bubble; tlast only on 8'hDD.
- Partial beat 32'h12_34_ef_00, keep=4'hE, last=1:
  - Macro undefined -> four subbeats; the final one is 8'h00 with keep=0 and tlast=1.
  - Macro defined -> three subbeats; tlast on 8'hef.
- Backpressure: out_tready_i=0 for 4 cycles while 8'h34 is presented -> data is held stable, in_tready_o=0; the sequence resumes correctly when ready rises.
- Reset after 2 of 4 subbeats have been sent -> out_tvalid_o=0 the next cycle; a subsequent beat 32'h01_02_03_04 yields 8'h01 first.
